// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Holds the 800x600@60 and 640x480@60 mode tables and the counter width.
package vga_timing_pkg;

  localparam int CNT_W  = 11;
  localparam int FCNT_W = 16;
  localparam int CNT_MAX_TOTAL = 2048;

  // 800x600@60, 40 MHz pixel clock
  localparam int VGA800_H_ACTIVE     = 800;
  localparam int VGA800_H_SYNC_START = 840;
  localparam int VGA800_H_SYNC_END   = 968;
  localparam int VGA800_H_TOTAL      = 1056;
  localparam int VGA800_V_ACTIVE     = 600;
  localparam int VGA800_V_SYNC_START = 601;
  localparam int VGA800_V_SYNC_END   = 605;
  localparam int VGA800_V_TOTAL      = 628;

  // 640x480@60, 25 MHz pixel clock
  localparam int VGA640_H_ACTIVE     = 640;
  localparam int VGA640_H_SYNC_START = 656;
  localparam int VGA640_H_SYNC_END   = 752;
  localparam int VGA640_H_TOTAL      = 800;
  localparam int VGA640_V_ACTIVE     = 480;
  localparam int VGA640_V_SYNC_START = 490;
  localparam int VGA640_V_SYNC_END   = 492;
  localparam int VGA640_V_TOTAL      = 525;

  function automatic bit timing_ok(int active, int sync_start, int sync_end, int total);
    return (active < sync_start) && (sync_start < sync_end) &&
           (sync_end <= total) && (total <= CNT_MAX_TOTAL);
  endfunction

  function automatic logic in_window(logic [CNT_W-1:0] val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the overlay chain.
// The generator drives it (master); downstream stages only observe it (slave).
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic [CNT_W-1:0]  hcount_out;
  logic [CNT_W-1:0]  vcount_out;
  logic              hsync_out;
  logic              vsync_out;
  logic              hblnk_out;
  logic              vblnk_out;
  logic              frame_tick;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output hcount_out, vcount_out, hsync_out, vsync_out,
           hblnk_out, vblnk_out, frame_tick, frame_cnt
  );

  modport slave (
    input hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, frame_tick, frame_cnt
  );
endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-N counter; exposes registered count, combinational next count and wrap.
// One-cycle update when en_i=1, holds otherwise; no backpressure.
module vga_wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int N = VGA800_H_TOTAL,
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign nxt_o = cnt_d;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing: counters, sync/blank flags, frame tick and count, all registered together (1 clk).
// No backpressure; with VGA_TIMING_CKE_EN defined, a pix_en input qualifies every update.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = VGA800_H_ACTIVE,
  parameter int H_SYNC_START = VGA800_H_SYNC_START,
  parameter int H_SYNC_END   = VGA800_H_SYNC_END,
  parameter int H_TOTAL      = VGA800_H_TOTAL,
  parameter int V_ACTIVE     = VGA800_V_ACTIVE,
  parameter int V_SYNC_START = VGA800_V_SYNC_START,
  parameter int V_SYNC_END   = VGA800_V_SYNC_END,
  parameter int V_TOTAL      = VGA800_V_TOTAL,
  parameter bit SYNC_POL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
`ifdef VGA_TIMING_CKE_EN
  input  logic pix_en,
`endif
  vga_timing_if.master vga
);

  generate
    if (!timing_ok(H_ACTIVE, H_SYNC_START, H_SYNC_END, H_TOTAL)) begin : g_bad_h
      $error("vga_timing_gen: illegal horizontal timing parameters");
    end
    if (!timing_ok(V_ACTIVE, V_SYNC_START, V_SYNC_END, V_TOTAL)) begin : g_bad_v
      $error("vga_timing_gen: illegal vertical timing parameters");
    end
  endgenerate

  logic en;
`ifdef VGA_TIMING_CKE_EN
  assign en = pix_en;
`else
  assign en = 1'b1;
`endif

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_wrap, v_wrap;

  vga_wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_hcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en),
    .cnt_o  (h_q),
    .nxt_o  (h_d),
    .wrap_o (h_wrap)
  );

  // The vertical wrap coincides with the horizontal wrap of the last line: that is the frame edge.
  vga_wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_vcnt (
    .clk    (clk),
    .rst    (rst),
    .en_i   (h_wrap),
    .cnt_o  (v_q),
    .nxt_o  (v_d),
    .wrap_o (v_wrap)
  );

  logic              hsync_q, vsync_q, hblnk_q, vblnk_q, tick_q;
  logic              hsync_d, vsync_d, hblnk_d, vblnk_d;
  logic [FCNT_W-1:0] fcnt_q;

  // Flags come from the next counter values so they land in the same cycle as the counts.
  always_comb begin
    hsync_d = in_window(h_d, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d = in_window(v_d, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    hblnk_d = (int'(h_d) >= H_ACTIVE);
    vblnk_d = (int'(v_d) >= V_ACTIVE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      hblnk_q <= 1'b0;
      vblnk_q <= 1'b0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
    end else if (en) begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      hblnk_q <= hblnk_d;
      vblnk_q <= vblnk_d;
      tick_q  <= v_wrap;
      if (v_wrap) begin
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  assign vga.hcount_out = h_q;
  assign vga.vcount_out = v_q;
  assign vga.hsync_out  = hsync_q;
  assign vga.vsync_out  = vsync_q;
  assign vga.hblnk_out  = hblnk_q;
  assign vga.vblnk_out  = vblnk_q;
  assign vga.frame_tick = tick_q;
  assign vga.frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so whole frames fit in a short run.
// A behavioural raster model feeds a scoreboard queue that is checked every cycle.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA  = 40;
  localparam int HSS = 44;
  localparam int HSE = 48;
  localparam int HT  = 52;
  localparam int VA  = 10;
  localparam int VSS = 11;
  localparam int VSE = 13;
  localparam int VT  = 16;
  localparam bit POL = 1'b1;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef VGA_TIMING_CKE_EN
  logic pix_en = 1'b1;
`endif

  vga_timing_if vif ();

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .SYNC_POL(POL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef VGA_TIMING_CKE_EN
    .pix_en (pix_en),
`endif
    .vga    (vif.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0]  h;
    logic [CNT_W-1:0]  v;
    logic              hs;
    logic              vs;
    logic              hb;
    logic              vb;
    logic              tk;
    logic [FCNT_W-1:0] fc;
  } obs_t;

  obs_t sbq[$];
  int total = 0;
  int bad   = 0;

  int                mh, mv;
  logic [FCNT_W-1:0] mfc;
  logic              mtick;

  function automatic obs_t model_out();
    obs_t o;
    o.h  = CNT_W'(mh);
    o.v  = CNT_W'(mv);
    o.hs = (mh >= HSS && mh < HSE) ? POL : ~POL;
    o.vs = (mv >= VSS && mv < VSE) ? POL : ~POL;
    o.hb = (mh >= HA);
    o.vb = (mv >= VA);
    o.tk = mtick;
    o.fc = mfc;
    return o;
  endfunction

  function automatic obs_t dut_out();
    obs_t o;
    o.h  = vif.hcount_out;
    o.v  = vif.vcount_out;
    o.hs = vif.hsync_out;
    o.vs = vif.vsync_out;
    o.hb = vif.hblnk_out;
    o.vb = vif.vblnk_out;
    o.tk = vif.frame_tick;
    o.fc = vif.frame_cnt;
    return o;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mfc = '0; mtick = 1'b0;
  endtask

  task automatic model_adv(input logic en);
    if (en) begin
      mtick = (mh == HT - 1) && (mv == VT - 1);
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      if (mtick) mfc = mfc + 16'd1;
    end
  endtask

  task automatic step(input logic en);
    obs_t exp_o, got_o;
`ifdef VGA_TIMING_CKE_EN
    pix_en = en;
`endif
    model_adv(en);
    sbq.push_back(model_out());
    @(posedge clk);
    #1;
    got_o = dut_out();
    exp_o = sbq.pop_front();
    total++;
    if (got_o !== exp_o) begin
      bad++;
      $display("FAIL stream at model (%0d,%0d): got=%h exp=%h", mh, mv, got_o, exp_o);
    end
  endtask

  task automatic advance_to(input int h, input int v);
    for (int i = 0; i <= FRAME && !(mh == h && mv == v); i++) step(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (dut_out() !== model_out()) begin
      bad++; $display("FAIL reset_state got=%h exp=%h", dut_out(), model_out());
    end
    rst = 1'b0;
    step(1'b1);
    total++;
    if (vif.hcount_out !== 11'd1 || vif.vcount_out !== 11'd0) begin
      bad++; $display("FAIL first_edge got=(%0d,%0d) exp=(1,0)", vif.hcount_out, vif.vcount_out);
    end
  endtask

  task automatic test_hline();
    advance_to(HA - 1, 0);
    total++; if (vif.hblnk_out !== 1'b0) begin bad++; $display("FAIL hblnk_pre got=%b exp=0", vif.hblnk_out); end
    step(1'b1);
    total++; if (vif.hblnk_out !== 1'b1) begin bad++; $display("FAIL hblnk_rise got=%b exp=1", vif.hblnk_out); end
    advance_to(HSS - 1, 0);
    total++; if (vif.hsync_out !== ~POL) begin bad++; $display("FAIL hsync_pre got=%b exp=%b", vif.hsync_out, ~POL); end
    step(1'b1);
    total++; if (vif.hsync_out !== POL) begin bad++; $display("FAIL hsync_rise got=%b exp=%b", vif.hsync_out, POL); end
    advance_to(HSE - 1, 0);
    total++; if (vif.hsync_out !== POL) begin bad++; $display("FAIL hsync_last got=%b exp=%b", vif.hsync_out, POL); end
    step(1'b1);
    total++; if (vif.hsync_out !== ~POL) begin bad++; $display("FAIL hsync_fall got=%b exp=%b", vif.hsync_out, ~POL); end
    advance_to(HT - 1, 0);
    step(1'b1);
    total++;
    if (vif.hcount_out !== 11'd0 || vif.vcount_out !== 11'd1) begin
      bad++; $display("FAIL line_wrap got=(%0d,%0d) exp=(0,1)", vif.hcount_out, vif.vcount_out);
    end
  endtask

  task automatic test_vert();
    advance_to(HT - 1, VA - 1);
    total++; if (vif.vblnk_out !== 1'b0) begin bad++; $display("FAIL vblnk_pre got=%b exp=0", vif.vblnk_out); end
    step(1'b1);
    total++; if (vif.vblnk_out !== 1'b1) begin bad++; $display("FAIL vblnk_rise got=%b exp=1", vif.vblnk_out); end
    advance_to(HT - 1, VSS - 1);
    total++; if (vif.vsync_out !== ~POL) begin bad++; $display("FAIL vsync_pre got=%b exp=%b", vif.vsync_out, ~POL); end
    step(1'b1);
    total++; if (vif.vsync_out !== POL) begin bad++; $display("FAIL vsync_rise got=%b exp=%b", vif.vsync_out, POL); end
    advance_to(HT - 1, VSE - 1);
    total++; if (vif.vsync_out !== POL) begin bad++; $display("FAIL vsync_last got=%b exp=%b", vif.vsync_out, POL); end
    step(1'b1);
    total++; if (vif.vsync_out !== ~POL) begin bad++; $display("FAIL vsync_fall got=%b exp=%b", vif.vsync_out, ~POL); end
  endtask

  task automatic test_frame();
    for (int i = 0; i <= FRAME && !mtick; i++) step(1'b1);
    total++;
    if (vif.frame_tick !== 1'b1 || vif.frame_cnt !== 16'd1) begin
      bad++; $display("FAIL frame1 got tick=%b cnt=%0d exp tick=1 cnt=1", vif.frame_tick, vif.frame_cnt);
    end
    step(1'b1);
    total++; if (vif.frame_tick !== 1'b0) begin bad++; $display("FAIL tick_clear got=%b exp=0", vif.frame_tick); end
    for (int i = 0; i <= FRAME && !mtick; i++) step(1'b1);
    total++;
    if (vif.frame_tick !== 1'b1 || vif.frame_cnt !== 16'd2) begin
      bad++; $display("FAIL frame2 got tick=%b cnt=%0d exp tick=1 cnt=2", vif.frame_tick, vif.frame_cnt);
    end
  endtask

  task automatic test_mid_reset();
    advance_to(HA / 2, VA / 2);
    #3 rst = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_out() !== model_out()) begin
      bad++; $display("FAIL mid_reset got=%h exp=%h", dut_out(), model_out());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i <= FRAME && !mtick; i++) step(1'b1);
    total++;
    if (vif.frame_cnt !== 16'd1) begin
      bad++; $display("FAIL post_reset_frame got=%0d exp=1", vif.frame_cnt);
    end
  endtask

`ifdef VGA_TIMING_CKE_EN
  task automatic test_cke();
    obs_t snap;
    int   h0;
    advance_to(0, 2);
    h0 = mh;
    for (int i = 0; i < 8; i++) step(i % 4 == 0);
    total++;
    if (int'(vif.hcount_out) !== h0 + 2) begin
      bad++; $display("FAIL cke_rate got=%0d exp=%0d", vif.hcount_out, h0 + 2);
    end
    snap = dut_out();
    repeat (100) step(1'b0);
    total++;
    if (dut_out() !== snap) begin
      bad++; $display("FAIL cke_hold got=%h exp=%h", dut_out(), snap);
    end
    pix_en = 1'b1;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_hline();
    test_vert();
    test_frame();
    test_mid_reset();
`ifdef VGA_TIMING_CKE_EN
    test_cke();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
